edge_strober: RTL and testbench

Multi-channel, parametrised edge-to-pulse converter. Each channel turns a level input into a strobe of configurable length on the rising edge, the falling edge, or both, selected per channel at run time. An optional input synchroniser lets asynchronous levels enter directly. It sits between raw status/level signals and control logic that needs one event per transition.

---
 rtl/edge_strober.sv | 117 +++++++++++
 tb/tb_edge_strober.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/edge_strober.sv
// Multi-channel edge-to-pulse converter with optional input synchroniser.
// Define STROBER_STICKY_EN to enable sticky status flags and irq.
module edge_strober #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [CHANNELS-1:0]   signal,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   strobe,
    output logic                  strobe_any,
    output logic [CHANNELS-1:0]   status,
    input  logic [CHANNELS-1:0]   clear,
    output logic                  irq
);

    localparam int            CW   = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);

    logic [CHANNELS-1:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = signal;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;

            always_comb begin
                sync_d[0] = signal;
                for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) sync_q <= '0;
                else         sync_q <= sync_d;
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Mode bit 0 selects rising edges, bit 1 selects falling edges.
    function automatic logic edge_sel(input logic [1:0] m, input logic r, input logic f);
        return (m[0] & r) | (m[1] & f);
    endfunction

    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] strobe_q, strobe_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic                strobe_any_q, strobe_any_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        prev_d = s;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]    = '0;
            strobe_d[i] = (cnt_q[i] != '0);
            if (mode[2*i +: 2] == 2'b00)
                cnt_d[i] = '0;
            else if (edge_sel(mode[2*i +: 2], s[i] & ~prev_q[i], ~s[i] & prev_q[i]))
                cnt_d[i] = LOAD;
            else if (cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - CW'(1);
        end
        strobe_any_d = |strobe_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q       <= '0;
            strobe_q     <= '0;
            strobe_any_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            prev_q       <= prev_d;
            strobe_q     <= strobe_d;
            strobe_any_q <= strobe_any_d;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign strobe     = strobe_q;
    assign strobe_any = strobe_any_q;

`ifdef STROBER_STICKY_EN
    logic [CHANNELS-1:0] status_q, status_d;
    logic                irq_q, irq_d;

    // Set has priority over clear; retrigger extensions do not count as new events.
    always_comb begin
        status_d = (status_q & ~clear) | (strobe_d & ~strobe_q);
        irq_d    = |status_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign status = status_q;
    assign irq    = irq_q;
`else
    logic unused_clear;
    assign unused_clear = ^clear;
    assign status       = '0;
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_edge_strober.sv
// Directed bench for edge_strober: a 4-channel synchronised instance (PULSE_LEN=3)
// and a 1-channel unsynchronised instance (PULSE_LEN=1).
module tb_edge_strober;

`ifdef STROBER_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [3:0] sig, clr, strobe, status;
    logic [7:0] md;
    logic       strobe_any, irq;

    logic       sig_b, clr_b, strobe_b, strobe_any_b, status_b, irq_b;
    logic [1:0] md_b;

    int n_total = 0;
    int n_bad   = 0;

    edge_strober #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(3)) dut_a (
        .clk(clk), .resetn(resetn), .signal(sig), .mode(md), .strobe(strobe),
        .strobe_any(strobe_any), .status(status), .clear(clr), .irq(irq)
    );

    edge_strober #(.CHANNELS(1), .SYNC_STAGES(0), .PULSE_LEN(1)) dut_b (
        .clk(clk), .resetn(resetn), .signal(sig_b), .mode(md_b), .strobe(strobe_b),
        .strobe_any(strobe_any_b), .status(status_b), .clear(clr_b), .irq(irq_b)
    );

    function automatic logic [3:0] st(input logic [3:0] v);
        return STK ? v : 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_a(input string tag, input logic [3:0] exp);
        @(negedge clk);
        check({tag, ".strobe"}, strobe, exp);
        check({tag, ".any"}, 4'(strobe_any), 4'(|exp));
    endtask

    task automatic step_b(input string tag, input logic exp);
        @(negedge clk);
        check({tag, ".strobe_b"}, 4'(strobe_b), 4'(exp));
        check({tag, ".any_b"}, 4'(strobe_any_b), 4'(exp));
    endtask

    initial begin
        resetn = 1'b0;
        sig    = 4'b0000;
        md     = 8'b00_11_10_01;
        clr    = 4'b0000;
        sig_b  = 1'b0;
        md_b   = 2'b01;
        clr_b  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst.strobe", strobe, 4'b0000);
        check("rst.any", 4'(strobe_any), 4'b0);
        check("rst.status", status, 4'b0000);
        check("rst.irq", 4'(irq), 4'b0);
        check("rst.strobe_b", 4'(strobe_b), 4'b0);
        resetn = 1'b1;
        repeat (4) step_a("idle", 4'b0000);

        // All rise together: rise, fall, both, off
        sig = 4'hF;
        for (int j = 0; j < 8; j++) begin
            step_a("rise_all", (j >= 3 && j <= 5) ? 4'b0101 : 4'b0000);
            if (j == 3) begin
                check("rise_all.status", status, st(4'b0101));
                check("rise_all.irq", 4'(irq), 4'(STK));
            end
        end

        // Enabling ch3 while its level is held high
        md[7:6] = 2'b01;
        repeat (6) step_a("mode_chg", 4'b0000);

        clr = 4'hF;
        step_a("clr1", 4'b0000);
        clr = 4'h0;
        check("clr1.status", status, 4'b0000);
        check("clr1.irq", 4'(irq), 4'b0);

        // All fall: ch1 (fall) and ch2 (both) fire
        sig = 4'h0;
        for (int j = 0; j < 8; j++) begin
            step_a("fall_all", (j >= 3 && j <= 5) ? 4'b0110 : 4'b0000);
            if (j == 3) check("fall_all.status", status, st(4'b0110));
        end

        // Rise again with clear coinciding with the new strobe
        sig = 4'hF;
        for (int j = 0; j < 8; j++) begin
            step_a("set_clr", (j >= 3 && j <= 5) ? 4'b1101 : 4'b0000);
            if (j == 2) clr = 4'hF;
            if (j == 3) begin
                clr = 4'h0;
                check("set_clr.status", status, st(4'b1101));
                check("set_clr.irq", 4'(irq), 4'(STK));
            end
        end
        clr = 4'hF;
        step_a("clr2", 4'b0000);
        clr = 4'h0;
        check("clr2.status", status, 4'b0000);
        check("clr2.irq", 4'(irq), 4'b0);

        // Retrigger on ch2: fall then rise two cycles apart
        sig[2] = 1'b0;
        for (int j = 0; j < 9; j++) begin
            step_a("retrig", (j >= 3 && j <= 7) ? 4'b0100 : 4'b0000);
            if (j == 1) sig[2] = 1'b1;
            if (j == 3) begin
                check("retrig.status_set", status, st(4'b0100));
                clr = 4'b0100;
            end
            if (j == 4) begin
                clr = 4'h0;
                check("retrig.status_clr", status, 4'b0000);
            end
            if (j == 8) begin
                check("retrig.status_end", status, 4'b0000);
                check("retrig.irq_end", 4'(irq), 4'b0);
            end
        end

        // Mode 00 cuts an active pulse on ch0
        sig[0] = 1'b0;
        repeat (6) step_a("ch0_low", 4'b0000);
        sig[0] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            step_a("cut", (j == 3 || j == 4) ? 4'b0001 : 4'b0000);
            if (j == 3) begin
                check("cut.status", status, st(4'b0001));
                md[1:0] = 2'b00;
            end
        end
        md[1:0] = 2'b01;
        repeat (4) step_a("reenable", 4'b0000);

        sig = 4'h0;
        for (int j = 0; j < 8; j++) step_a("fall2", (j >= 3 && j <= 5) ? 4'b0110 : 4'b0000);

        // Reset mid-pulse, then input held high across release
        sig[0] = 1'b1;
        for (int j = 0; j < 4; j++) step_a("pre_rst", (j == 3) ? 4'b0001 : 4'b0000);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst.strobe", strobe, 4'b0000);
        check("mid_rst.any", 4'(strobe_any), 4'b0);
        check("mid_rst.status", status, 4'b0000);
        check("mid_rst.irq", 4'(irq), 4'b0);
        @(negedge clk);
        resetn = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step_a("post_rst", (j >= 4 && j <= 6) ? 4'b0001 : 4'b0000);
            if (j == 4) check("post_rst.status", status, st(4'b0001));
        end

        // Unsynchronised channel: one-cycle latency, rise only
        sig_b = 1'b1;
        for (int j = 0; j < 4; j++) step_b("b_rise", j == 1);
        sig_b = 1'b0;
        repeat (3) step_b("b_nofall", 1'b0);

        // Continuous toggling in mode 11 with PULSE_LEN=1
        md_b = 2'b11;
        for (int i = 0; i < 4; i++) begin
            sig_b = ~sig_b;
            step_b("b_toggle", i > 0);
        end
        step_b("b_tail", 1'b1);
        step_b("b_done", 1'b0);
        check("b.status", 4'(status_b), 4'(STK));
        check("b.irq", 4'(irq_b), 4'(STK));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
